adc_frame_packer: RTL and testbench

Sits directly upstream of the UART transmitter. It buffers ADC samples in a small FIFO and turns each sample into a fixed 4-byte frame: SYNC, sequence number, data high byte, data low byte. Bytes are presented one at a time on an 8-bit valid/ready interface. The transmitter takes a byte when it is idle, and the packer raises a sticky overflow flag when ADC samples arrive faster than the UART can drain them.

---
 rtl/adc_uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/adc_frame_packer.sv | 141 ++++++++++++++
 tb/tb_adc_frame_packer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_uart_pkg.sv
// Shared definitions for the ADC-to-UART framing path.
package adc_uart_pkg;

    // Framer state encoding
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        SEQ  = 3'd2,
        HI   = 3'd3,
        LO   = 3'd4
    } frame_state_e;

    localparam int unsigned FRAME_BYTES       = 4;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    // Guard against overrun/underrun so the count stays consistent
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full    = (count_q == LW'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rd_data = mem[rd_ptr_q];

    // Storage array; contents need no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_frame_packer.sv
// Buffers ADC samples and emits each as a 4-byte frame: SYNC, seq, data hi, data lo.
module adc_frame_packer
    import adc_uart_pkg::*;
#(
    parameter int unsigned ADC_WIDTH  = 12,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 RST_clk,
    input  logic                 RST,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 overflow,
    output logic [LVL_W-1:0]     fifo_level
);

    frame_state_e         state_q, state_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [7:0]           seq_q, seq_d;
    logic [ADC_WIDTH-1:0] sample_q, sample_d;
    logic                 overflow_q, overflow_d;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [ADC_WIDTH-1:0] fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 xfer;
    logic [15:0]          sample_ext;

    // Full is judged on the registered level, so a same-cycle pop never frees a slot
    assign fifo_push  = adc_valid && !fifo_full;
    assign overflow_d = overflow_q || (adc_valid && fifo_full);
    assign xfer       = tx_valid_q && tx_ready;
    assign sample_ext = 16'(sample_q);

    sync_fifo #(
        .WIDTH (ADC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (RST_clk),
        .rst     (RST),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (adc_data),
        .rd_data (fifo_rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next state and next registered byte outputs
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        seq_d      = seq_q;
        sample_d   = sample_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    sample_d   = fifo_rd_data;
                    state_d    = SYNC;
                    tx_valid_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                end
            end
            SYNC: begin
                if (xfer) begin
                    state_d   = SEQ;
                    tx_data_d = seq_q;
                end
            end
            SEQ: begin
                if (xfer) begin
                    state_d   = HI;
                    tx_data_d = sample_ext[15:8];
                end
            end
            HI: begin
                if (xfer) begin
                    state_d   = LO;
                    tx_data_d = sample_ext[7:0];
                end
            end
            LO: begin
                if (xfer) begin
                    seq_d = seq_q + 8'd1;
                    // Chain straight into the next frame when a sample is waiting
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        sample_d   = fifo_rd_data;
                        state_d    = SYNC;
                        tx_valid_d = 1'b1;
                        tx_data_d  = SYNC_BYTE;
                    end else begin
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase
    end

    // State, sequence, sample and output registers
    always_ff @(posedge RST_clk or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            seq_q      <= 8'h00;
            sample_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            seq_q      <= seq_d;
            sample_q   <= sample_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer with hand-computed byte streams.
module tb_adc_frame_packer;

    logic        RST_clk;
    logic        RST;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        overflow;
    logic [3:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    adc_frame_packer dut (
        .RST_clk    (RST_clk),
        .RST        (RST),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    initial RST_clk = 1'b0;
    always #5 RST_clk = ~RST_clk;

    task automatic tick();
        @(posedge RST_clk);
        #1;
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        adc_valid = 1'b0;
        adc_data  = 12'h000;
        tx_ready  = 1'b0;
        repeat (2) @(posedge RST_clk);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        adc_valid = 1'b0;
        adc_data  = 12'h000;
        tx_ready  = 1'b0;
        #2;
        checks++;
        if ({tx_data, tx_valid, overflow, fifo_level} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h valid=%b ovf=%b lvl=%0d want all 0",
                     tx_data, tx_valid, overflow, fifo_level);
        end
        @(posedge RST_clk);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] exp [4];
        exp = '{8'hA5, 8'h00, 8'h0A, 8'hBC};
        do_reset();
        tx_ready  = 1'b1;
        adc_data  = 12'hABC;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        checks++;
        if (tx_valid !== 1'b0 || fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL single_latency got valid=%b lvl=%0d want valid=0 lvl=1",
                     tx_valid, fifo_level);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
                errors++;
                $display("FAIL single_byte%0d got valid=%b data=%h want valid=1 data=%h",
                         i, tx_valid, tx_data, exp[i]);
            end
        end
        tick();
        checks++;
        if (tx_valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL single_end got valid=%b lvl=%0d want valid=0 lvl=0",
                     tx_valid, fifo_level);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        tx_ready  = 1'b1;
        adc_data  = 12'h123;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        tick();
        tick();
        tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
                errors++;
                $display("FAIL bp_hold%0d got valid=%b data=%h want valid=1 data=01",
                         i, tx_valid, tx_data);
            end
        end
        tx_ready = 1'b1;
        tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h23) begin
            errors++;
            $display("FAIL bp_lo got valid=%b data=%h want valid=1 data=23", tx_valid, tx_data);
        end
        tick();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end got valid=%b want 0", tx_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        int f;
        do_reset();
        tx_ready = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            adc_valid = (c < 3);
            adc_data  = 12'(c + 1);
            tick();
            if (c >= 1) begin
                f = (c - 1) / 4;
                case ((c - 1) % 4)
                    0:       want = 8'hA5;
                    1:       want = 8'(f);
                    2:       want = 8'h00;
                    default: want = 8'(f + 1);
                endcase
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== want) begin
                    errors++;
                    $display("FAIL b2b_byte%0d got valid=%b data=%h want valid=1 data=%h",
                             c - 1, tx_valid, tx_data, want);
                end
            end
        end
        adc_valid = 1'b0;
        tick();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got valid=%b want 0", tx_valid);
        end
    endtask

    // The first sample is popped into the frame register at once, so the FIFO
    // fills after the 9th pulse and the 10th is the one dropped.
    task automatic test_overflow();
        logic [7:0] want;
        int f;
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            adc_data  = 12'(12'h100 + i);
            adc_valid = 1'b1;
            tick();
            if (i == 8) begin
                checks++;
                if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full got lvl=%0d ovf=%b want lvl=8 ovf=0",
                             fifo_level, overflow);
                end
            end
        end
        adc_valid = 1'b0;
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got lvl=%0d ovf=%b want lvl=8 ovf=1", fifo_level, overflow);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 36; i++) begin
            f = i / 4;
            case (i % 4)
                0:       want = 8'hA5;
                1:       want = 8'(f);
                2:       want = 8'h01;
                default: want = 8'(f);
            endcase
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== want) begin
                errors++;
                $display("FAIL ovf_byte%0d got valid=%b data=%h want valid=1 data=%h",
                         i, tx_valid, tx_data, want);
            end
            tick();
        end
        checks++;
        if (tx_valid !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_end got valid=%b lvl=%0d ovf=%b want valid=0 lvl=0 ovf=1",
                     tx_valid, fifo_level, overflow);
        end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        tx_ready = 1'b1;
        for (int f = 0; f < 257; f++) begin
            adc_data  = 12'(f);
            adc_valid = 1'b1;
            tick();
            adc_valid = 1'b0;
            tick();
            tick();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(f)) begin
                errors++;
                $display("FAIL wrap_seq%0d got valid=%b data=%h want valid=1 data=%h",
                         f, tx_valid, tx_data, 8'(f));
            end
            tick();
            tick();
            tick();
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp [4];
        exp = '{8'hA5, 8'h00, 8'h04, 8'h56};
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adc_data  = 12'(12'h200 + i);
            adc_valid = 1'b1;
            tick();
        end
        adc_valid = 1'b0;
        tx_ready  = 1'b1;
        tick();
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h00 || fifo_level !== 4'd3) begin
            errors++;
            $display("FAIL mid_pre got valid=%b data=%h lvl=%0d want valid=1 data=00 lvl=3",
                     tx_valid, tx_data, fifo_level);
        end
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({tx_data, tx_valid, overflow, fifo_level} !== 14'h0) begin
            errors++;
            $display("FAIL mid_async got data=%h valid=%b ovf=%b lvl=%0d want all 0",
                     tx_data, tx_valid, overflow, fifo_level);
        end
        @(posedge RST_clk);
        #1;
        RST = 1'b0;
        tick();
        tick();
        checks++;
        if (tx_valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL mid_flushed got valid=%b lvl=%0d want valid=0 lvl=0",
                     tx_valid, fifo_level);
        end
        tx_ready  = 1'b1;
        adc_data  = 12'h456;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
                errors++;
                $display("FAIL mid_byte%0d got valid=%b data=%h want valid=1 data=%h",
                         i, tx_valid, tx_data, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_seq_wrap();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
